// File: rtl/simt_pc_pkg.sv
// Shared constants and types for the SIMT program counter and its reconvergence stack.
package simt_pc_pkg;

  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE  = 3'b110;

  // PATH entries resume a deferred branch path; JOIN entries restore the pre-branch mask.
  typedef enum logic {
    PATH = 1'b0,
    JOIN = 1'b1
  } entry_kind_t;

  function automatic int unsigned depth_bits(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/simt_pc_if.sv
// Decoder/ALU-side bundle feeding simt_pc, plus its PC/mask/stack status outputs.
// No handshake: every input is sampled each clk; outputs are registered and always valid.
interface simt_pc_if #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int DATA_MEM_DATA_BITS    = 16,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4
);
  localparam int SD_BITS = $clog2(STACK_DEPTH + 1);

  logic [THREADS_PER_BLOCK-1:0]                    thread_enable;
  logic [2:0]                                      core_state;
  logic [2:0]                                      decoded_nzp;
  logic [7:0]                                      decoded_immediate;
  logic                                            decoded_nzp_write_enable;
  logic                                            decoded_pc_mux;
  logic                                            decoded_sync;
  logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] alu_out;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]                current_pc;

  logic [PROGRAM_MEM_ADDR_BITS-1:0]                next_pc;
  logic [THREADS_PER_BLOCK-1:0]                    active_mask;
  logic [SD_BITS-1:0]                              stack_depth;
  logic                                            diverged;
  logic                                            stack_overflow;
  logic                                            stack_underflow;
  logic [3*THREADS_PER_BLOCK-1:0]                  nzp_dbg;

  modport master (
    output thread_enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_sync, alu_out, current_pc,
    input  next_pc, active_mask, stack_depth, diverged, stack_overflow, stack_underflow, nzp_dbg
  );

  modport slave (
    input  thread_enable, core_state, decoded_nzp, decoded_immediate,
           decoded_nzp_write_enable, decoded_pc_mux, decoded_sync, alu_out, current_pc,
    output next_pc, active_mask, stack_depth, diverged, stack_overflow, stack_underflow, nzp_dbg
  );

endinterface

// File: rtl/simt_recon_stack.sv
// Reconvergence LIFO: pushes two entries atomically (lo below hi) or pops one per cycle.
module simt_recon_stack #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push2,
  input  logic [WIDTH-1:0]               push_lo,
  input  logic [WIDTH-1:0]               push_hi,
  input  logic                           pop,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic [$clog2(DEPTH+1)-1:0]     free_count
);
  localparam int DB = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DB-1:0]    depth_q;

  assign depth      = depth_q;
  assign free_count = DB'(DEPTH) - depth_q;

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DB'(i + 1) == depth_q) top = mem[i];
    end
  end

  // Storage is not cleared on reset; depth alone defines what is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
    end else if (push2 && free_count >= DB'(2)) begin
      depth_q <= depth_q + DB'(2);
      for (int i = 0; i < DEPTH; i++) begin
        if (DB'(i) == depth_q)          mem[i] <= push_lo;
        if (DB'(i) == depth_q + DB'(1)) mem[i] <= push_hi;
      end
    end else if (pop && depth_q != '0) begin
      depth_q <= depth_q - DB'(1);
    end
  end

endmodule

// File: rtl/simt_pc.sv
// Per-block SIMT program counter: per-lane NZP flags, active mask, divergent branches
// serialised through a reconvergence stack and rejoined at SYNC.
module simt_pc
  import simt_pc_pkg::*;
#(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int DATA_MEM_DATA_BITS    = 16,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4
) (
  input logic       clk,
  input logic       reset,
  simt_pc_if.slave  bus
);
  localparam int T   = THREADS_PER_BLOCK;
  localparam int D   = DATA_MEM_DATA_BITS;
  localparam int PCB = PROGRAM_MEM_ADDR_BITS;
  localparam int SDB = depth_bits(STACK_DEPTH);

  typedef struct packed {
    entry_kind_t    kind;
    logic [PCB-1:0] pc;
    logic [T-1:0]   mask;
  } stack_entry_t;

  localparam int EB = $bits(stack_entry_t);

  logic [PCB-1:0] next_pc_q, next_pc_d;
  logic [T-1:0]   mask_q, mask_d;
  logic [2:0]     nzp_q [T];
  logic           ovf_q, unf_q;

  logic [T-1:0]   eff, taken;
  logic [PCB-1:0] pc_inc, target;
  logic           is_exec, divergent, can_push;
  logic           push2, pop, ovf_evt, unf_evt;
  stack_entry_t   join_e, path_e, top_e;
  logic [EB-1:0]  top_bits;
  logic [SDB-1:0] depth, free_count;

  simt_recon_stack #(.WIDTH(EB), .DEPTH(STACK_DEPTH)) u_stack (
    .clk        (clk),
    .reset      (reset),
    .push2      (push2),
    .push_lo    (join_e),
    .push_hi    (path_e),
    .pop        (pop),
    .top        (top_bits),
    .depth      (depth),
    .free_count (free_count)
  );

  always_comb begin
    eff   = mask_q & bus.thread_enable;
    taken = '0;
    for (int i = 0; i < T; i++) begin
      taken[i] = eff[i] & |(nzp_q[i] & bus.decoded_nzp);
    end
    pc_inc    = bus.current_pc + PCB'(1);
    target    = PCB'(bus.decoded_immediate);
    is_exec   = (bus.core_state == EXECUTE);
    divergent = (taken != '0) && (taken != eff);
    can_push  = (free_count >= SDB'(2));
    push2     = is_exec && bus.decoded_pc_mux && divergent && can_push;
    ovf_evt   = is_exec && bus.decoded_pc_mux && divergent && !can_push;
    pop       = is_exec && !bus.decoded_pc_mux && bus.decoded_sync && (depth != '0);
    unf_evt   = is_exec && !bus.decoded_pc_mux && bus.decoded_sync && (depth == '0);
    join_e    = '{kind: JOIN, pc: pc_inc, mask: eff};
    path_e    = '{kind: PATH, pc: pc_inc, mask: eff & ~taken};
    top_e     = stack_entry_t'(top_bits);
  end

  // Priority: branch, then SYNC, then sequential fetch; non-EXECUTE states hold.
  always_comb begin
    next_pc_d = next_pc_q;
    mask_d    = mask_q;
    if (is_exec) begin
      next_pc_d = pc_inc;
      if (bus.decoded_pc_mux) begin
        if (taken != '0 && taken == eff) begin
          next_pc_d = target;
        end else if (push2) begin
          next_pc_d = target;
          mask_d    = taken;
        end
      end else if (pop) begin
        mask_d = top_e.mask;
        if (top_e.kind == PATH) next_pc_d = top_e.pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pc_q <= '0;
      mask_q    <= '1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      for (int i = 0; i < T; i++) nzp_q[i] <= 3'b000;
    end else begin
      next_pc_q <= next_pc_d;
      mask_q    <= mask_d;
      if (ovf_evt) ovf_q <= 1'b1;
      if (unf_evt) unf_q <= 1'b1;
      if (bus.core_state == UPDATE && bus.decoded_nzp_write_enable) begin
        for (int i = 0; i < T; i++) begin
          if (eff[i]) nzp_q[i] <= bus.alu_out[i*D +: 3];
        end
      end
    end
  end

  always_comb begin
    bus.nzp_dbg = '0;
    for (int i = 0; i < T; i++) bus.nzp_dbg[i*3 +: 3] = nzp_q[i];
  end

  assign bus.next_pc         = next_pc_q;
  assign bus.active_mask     = mask_q;
  assign bus.stack_depth     = depth;
  assign bus.diverged        = (depth != '0);
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;

endmodule
